// File: rtl/batch_2_sdiv_seq.sv
// Radix-2 restoring divider: signed dividend / unsigned divisor, one quotient bit per clock.
// Define BATCH_2_SDIV_REM_EN to add the signed remainder output `rem`.
module batch_2_sdiv_seq #(
  parameter int din0_WIDTH = 35,
  parameter int din1_WIDTH = 9
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  din_vld,
  output logic                  din_rdy,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic [din0_WIDTH-1:0] dout,
`ifdef BATCH_2_SDIV_REM_EN
  output logic [din1_WIDTH-1:0] rem,
`endif
  output logic                  dbz
);

  localparam int W  = din0_WIDTH;
  localparam int D  = din1_WIDTH;
  localparam int CW = $clog2(din0_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [D-1:0]   rem_acc_q, rem_acc_d;
  logic [D-1:0]   divisor_q, divisor_d;
  logic           neg_q, neg_d;
  logic           din_rdy_q, din_rdy_d;
  logic           dout_vld_q, dout_vld_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           dbz_q, dbz_d;
`ifdef BATCH_2_SDIV_REM_EN
  logic [D-1:0]   rem_q, rem_d;
`endif
  logic [D:0]     partial;

  // dvd_q starts as |dividend| and is shifted left, collecting quotient bits in its LSBs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    rem_acc_d  = rem_acc_q;
    divisor_d  = divisor_q;
    neg_d      = neg_q;
    din_rdy_d  = din_rdy_q;
    dout_vld_d = dout_vld_q;
    dout_d     = dout_q;
    dbz_d      = dbz_q;
`ifdef BATCH_2_SDIV_REM_EN
    rem_d      = rem_q;
`endif
    partial    = {rem_acc_q, dvd_q[W-1]};

    case (state_q)
      IDLE: begin
        din_rdy_d = 1'b1;
        if (din_vld && din_rdy_q) begin
          neg_d     = din0[W-1];
          dvd_d     = din0[W-1] ? (W'(0) - din0) : din0;
          divisor_d = din1;
          rem_acc_d = '0;
          cnt_d     = CW'(W - 1);
          din_rdy_d = 1'b0;
          if (din1 == '0) begin
            state_d    = DONE;
            dout_vld_d = 1'b1;
            dbz_d      = 1'b1;
            dout_d     = din0[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`ifdef BATCH_2_SDIV_REM_EN
            rem_d      = '0;
`endif
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (partial >= {1'b0, divisor_q}) begin
          rem_acc_d = D'(partial - {1'b0, divisor_q});
          dvd_d     = {dvd_q[W-2:0], 1'b1};
        end else begin
          rem_acc_d = partial[D-1:0];
          dvd_d     = {dvd_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        dout_d     = neg_q ? (W'(0) - dvd_q) : dvd_q;
`ifdef BATCH_2_SDIV_REM_EN
        rem_d      = neg_q ? (D'(0) - rem_acc_q) : rem_acc_q;
`endif
        dbz_d      = 1'b0;
        dout_vld_d = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        if (dout_rdy) begin
          dout_vld_d = 1'b0;
          din_rdy_d  = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      rem_acc_q  <= '0;
      divisor_q  <= '0;
      neg_q      <= 1'b0;
      din_rdy_q  <= 1'b0;
      dout_vld_q <= 1'b0;
      dout_q     <= '0;
      dbz_q      <= 1'b0;
`ifdef BATCH_2_SDIV_REM_EN
      rem_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      rem_acc_q  <= rem_acc_d;
      divisor_q  <= divisor_d;
      neg_q      <= neg_d;
      din_rdy_q  <= din_rdy_d;
      dout_vld_q <= dout_vld_d;
      dout_q     <= dout_d;
      dbz_q      <= dbz_d;
`ifdef BATCH_2_SDIV_REM_EN
      rem_q      <= rem_d;
`endif
    end
  end

  assign din_rdy  = din_rdy_q;
  assign dout_vld = dout_vld_q;
  assign dout     = dout_q;
  assign dbz      = dbz_q;
`ifdef BATCH_2_SDIV_REM_EN
  assign rem      = rem_q;
`endif

endmodule

// File: tb/tb_batch_2_sdiv_seq.sv
// Directed self-checking bench for batch_2_sdiv_seq; remainder checks apply when BATCH_2_SDIV_REM_EN is defined.
module tb_batch_2_sdiv_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        din_vld;
  logic        din_rdy;
  logic [34:0] din0;
  logic [8:0]  din1;
  logic        dout_vld;
  logic        dout_rdy;
  logic [34:0] dout;
`ifdef BATCH_2_SDIV_REM_EN
  logic [8:0]  rem;
`endif
  logic        dbz;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 ap_clk = ~ap_clk;

  batch_2_sdiv_seq #(.din0_WIDTH(35), .din1_WIDTH(9)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .din0     (din0),
    .din1     (din1),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .dout     (dout),
`ifdef BATCH_2_SDIV_REM_EN
    .rem      (rem),
`endif
    .dbz      (dbz)
  );

  // Expected values are written as signed integers and folded to the port width, zero-extended.
  function automatic logic [63:0] q35(input longint v);
    logic [34:0] t;
    t = v[34:0];
    return {29'b0, t};
  endfunction

  function automatic logic [63:0] r9(input longint v);
    logic [8:0] t;
    t = v[8:0];
    return {55'b0, t};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one operand pair, waits (bounded) for din_rdy, and returns #1 after the accept edge.
  task automatic applyStimulus(input longint a, input int b);
    int n;
    n = 0;
    @(negedge ap_clk);
    din0    = a[34:0];
    din1    = b[8:0];
    din_vld = 1'b1;
    while (!din_rdy && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    checkOutput("accept_timeout", 64'(n < 100), 64'(1));
    @(posedge ap_clk);
    #1;
    din_vld = 1'b0;
  endtask

  // Latency counts the accept cycle as 1; returns when dout_vld is seen or the budget runs out.
  task automatic waitResult(output int cyc);
    cyc = 1;
    while (!dout_vld && cyc < 100) begin
      @(posedge ap_clk);
      #1;
      cyc++;
    end
  endtask

  task automatic finishHandshake(input string tag);
    @(posedge ap_clk);
    #1;
    checkOutput({tag, "_vld_drop"}, 64'(dout_vld), 64'(0));
    checkOutput({tag, "_rdy_back"}, 64'(din_rdy), 64'(1));
  endtask

  initial begin
    ap_rst_n = 1'b0;
    din_vld  = 1'b0;
    din0     = '0;
    din1     = '0;
    dout_rdy = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    checkOutput("rst_din_rdy", 64'(din_rdy), 64'(0));
    checkOutput("rst_dout_vld", 64'(dout_vld), 64'(0));
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    checkOutput("rel_din_rdy", 64'(din_rdy), 64'(1));
    checkOutput("rel_dout_vld", 64'(dout_vld), 64'(0));
    checkOutput("rel_dout", 64'(dout), 64'(0));
    checkOutput("rel_dbz", 64'(dbz), 64'(0));

    // -1000 / 7 = -142 rem -6
    applyStimulus(-1000, 7);
    checkOutput("neg_busy", 64'(din_rdy), 64'(0));
    waitResult(lat);
    checkOutput("neg_latency", 64'(lat), 64'(37));
    checkOutput("neg_q", 64'(dout), q35(-142));
    checkOutput("neg_dbz", 64'(dbz), 64'(0));
`ifdef BATCH_2_SDIV_REM_EN
    checkOutput("neg_rem", 64'(rem), r9(-6));
`endif
    finishHandshake("neg");

    // Round trip: 26'sh2AAAAAA = -22369622, times 511
    applyStimulus(-64'sd22369622 * 511, 511);
    waitResult(lat);
    checkOutput("rt_latency", 64'(lat), 64'(37));
    checkOutput("rt_q", 64'(dout), q35(-22369622));
`ifdef BATCH_2_SDIV_REM_EN
    checkOutput("rt_rem", 64'(rem), r9(0));
`endif
    finishHandshake("rt");

    // Most negative dividend / 1
    applyStimulus(-64'sd17179869184, 1);
    waitResult(lat);
    checkOutput("min_q", 64'(dout), q35(-64'sd17179869184));
    checkOutput("min_dbz", 64'(dbz), 64'(0));
    finishHandshake("min");

    // 5 / 0 saturates positive, one-cycle result
    applyStimulus(5, 0);
    waitResult(lat);
    checkOutput("dbz_pos_latency", 64'(lat), 64'(1));
    checkOutput("dbz_pos_flag", 64'(dbz), 64'(1));
    checkOutput("dbz_pos_q", 64'(dout), q35(64'sd17179869183));
`ifdef BATCH_2_SDIV_REM_EN
    checkOutput("dbz_pos_rem", 64'(rem), r9(0));
`endif
    finishHandshake("dbz_pos");

    // -7 / 0 saturates negative
    applyStimulus(-7, 0);
    waitResult(lat);
    checkOutput("dbz_neg_flag", 64'(dbz), 64'(1));
    checkOutput("dbz_neg_q", 64'(dout), q35(-64'sd17179869184));
    finishHandshake("dbz_neg");

    // 510 / 511: quotient 0, remainder 510 wraps in the 9-bit signed field
    applyStimulus(510, 511);
    waitResult(lat);
    checkOutput("wrap_q", 64'(dout), q35(0));
    checkOutput("wrap_dbz", 64'(dbz), 64'(0));
`ifdef BATCH_2_SDIV_REM_EN
    checkOutput("wrap_rem", 64'(rem), r9(510));
`endif
    finishHandshake("wrap");

    // Backpressure: -300 / 256 = -1 rem -44, held 10 cycles while new operands are offered
    dout_rdy = 1'b0;
    applyStimulus(-300, 256);
    waitResult(lat);
    checkOutput("bp_latency", 64'(lat), 64'(37));
    @(negedge ap_clk);
    din0    = 35'd77;
    din1    = 9'd5;
    din_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge ap_clk);
      #1;
      checkOutput("bp_vld_hold", 64'(dout_vld), 64'(1));
      checkOutput("bp_q_hold", 64'(dout), q35(-1));
      checkOutput("bp_din_rdy", 64'(din_rdy), 64'(0));
`ifdef BATCH_2_SDIV_REM_EN
      checkOutput("bp_rem_hold", 64'(rem), r9(-44));
`endif
    end
    @(negedge ap_clk);
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    finishHandshake("bp");
    checkOutput("bp_q_after", 64'(dout), q35(-1));

    // Reset in the middle of a division
    applyStimulus(1000, 7);
    repeat (20) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_vld", 64'(dout_vld), 64'(0));
    checkOutput("mid_rst_q", 64'(dout), 64'(0));
    checkOutput("mid_rst_dbz", 64'(dbz), 64'(0));
    checkOutput("mid_rst_rdy", 64'(din_rdy), 64'(0));
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    checkOutput("mid_rel_rdy", 64'(din_rdy), 64'(1));
    checkOutput("mid_rel_vld", 64'(dout_vld), 64'(0));

    // 100 / 3 = 33 rem 1 after the aborted operation
    applyStimulus(100, 3);
    waitResult(lat);
    checkOutput("post_latency", 64'(lat), 64'(37));
    checkOutput("post_q", 64'(dout), q35(33));
    checkOutput("post_dbz", 64'(dbz), 64'(0));
`ifdef BATCH_2_SDIV_REM_EN
    checkOutput("post_rem", 64'(rem), r9(1));
`endif
    finishHandshake("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
